mesm6_timer_multi: RTL

Multi-channel, parametrised successor to the single-channel MESM-6 timer. Has NCH independent timer channels, each CNT_W bits wide. Each channel has its own prescaler, period, compare/PWM register, one-shot/periodic mode and up/up-down count mode. Sits on the MESM-6 peripheral bus as one device. Drives a level interrupt built from write-1-to-clear status bits and an NCH-bit PWM output.

---
 rtl/mesm6_timer_multi.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mesm6_timer_multi.sv
// mesm6_timer_multi -- NCH-channel MESM-6 peripheral timer.
//
// Every channel has its own counter, compare/PWM register, period register,
// 3-bit prescaler, one-shot/periodic mode and up/up-down count mode.
// Pending status bits are write-1-to-clear. They feed one level interrupt.
//
// Optional build macro: MESM6_TIMER_CAPTURE_EN
//   Adds the i_cap port and a per-channel capture register (reg 6).
//   Adds the CAP_PEND status bit (bit3) and the IEN_CAP control bit (bit5).
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   i_addr    [6:3] channel, [2:0] register, [14:7] ignored
//   i_rd      read strobe
//   i_wr      write strobe
//   i_wdata   write data
//   i_cap     capture inputs, async (only with MESM6_TIMER_CAPTURE_EN)
//   o_rdata   read data, combinational from i_addr, zero-extended
//   o_done    bus acknowledge, one cycle after any strobe
//   o_irq     level interrupt
//   o_pwm     per-channel PWM output (registered)
module mesm6_timer_multi #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [14:0]    i_addr,
  input  logic           i_rd,
  input  logic           i_wr,
  input  logic [47:0]    i_wdata,
`ifdef MESM6_TIMER_CAPTURE_EN
  input  logic [NCH-1:0] i_cap,
`endif
  output logic [47:0]    o_rdata,
  output logic           o_done,
  output logic           o_irq,
  output logic [NCH-1:0] o_pwm
);

  localparam logic [2:0] REG_CNT  = 3'd0;
  localparam logic [2:0] REG_CMP  = 3'd1;
  localparam logic [2:0] REG_PRD  = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam logic [2:0] REG_STS  = 3'd4;
  localparam logic [2:0] REG_PRS  = 3'd5;
`ifdef MESM6_TIMER_CAPTURE_EN
  localparam logic [2:0] REG_CAP  = 3'd6;
  localparam int unsigned CTRL_W  = 6;
`else
  localparam int unsigned CTRL_W  = 5;
`endif

  localparam int unsigned C_EN      = 0;
  localparam int unsigned C_IEN_PRD = 1;
  localparam int unsigned C_IEN_CMP = 2;
  localparam int unsigned C_PERIOD  = 3;
  localparam int unsigned C_UPDOWN  = 4;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [3:0]     addr_ch;
  logic [2:0]     addr_reg;
  logic [47:0]    rd_val [NCH];
  logic [NCH-1:0] irq_ch;
  logic           done_q;
  logic           unused_bits;

  assign addr_ch     = i_addr[6:3];
  assign addr_reg    = i_addr[2:0];
  assign unused_bits = ^{i_addr[14:7], i_wdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= i_rd | i_wr;
  end

  assign o_done = done_q;
  assign o_irq  = |irq_ch;

`ifdef MESM6_TIMER_CAPTURE_EN
  logic [NCH-1:0] cap_s1_q, cap_s2_q, cap_s3_q, cap_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_s1_q <= '0;
      cap_s2_q <= '0;
      cap_s3_q <= '0;
    end else begin
      cap_s1_q <= i_cap;
      cap_s2_q <= cap_s1_q;
      cap_s3_q <= cap_s2_q;
    end
  end

  assign cap_rise = cap_s2_q & ~cap_s3_q;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CNT_W-1:0]  cnt_q, cnt_d, cmp_q, cmp_d, prd_q, prd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              prd_pend_q, prd_pend_d, cmp_pend_q, cmp_pend_d;
    dir_e              dir_q, dir_d;
    logic [2:0]        prs_q, prs_d;
    logic [6:0]        pc_q, pc_d;
    logic              pwm_q;
    logic              wr_sel, wr_ovr, tick, run, prd_evt, cmp_evt;
    logic [47:0]       rd_ch;
`ifdef MESM6_TIMER_CAPTURE_EN
    logic [CNT_W-1:0]  cap_q, cap_d;
    logic              cap_pend_q, cap_pend_d;
`endif

    assign wr_sel  = i_wr && (addr_ch == 4'(g));
    // Bus writes to CNT, PRD and CTRL take priority over counting in the same cycle.
    assign wr_ovr  = wr_sel && ((addr_reg == REG_CNT) || (addr_reg == REG_PRD) ||
                                (addr_reg == REG_CTRL));
    assign tick    = (pc_q & ~(7'h7f << prs_q)) == 7'd0;
    assign run     = ctrl_q[C_EN] && tick && !wr_ovr;
    assign cmp_evt = run && (cnt_q == cmp_q);

    always_comb begin
      cnt_d      = cnt_q;
      cmp_d      = cmp_q;
      prd_d      = prd_q;
      ctrl_d     = ctrl_q;
      dir_d      = dir_q;
      prs_d      = prs_q;
      pc_d       = pc_q + 7'd1;
      prd_evt    = 1'b0;
      prd_pend_d = prd_pend_q;
      cmp_pend_d = cmp_pend_q;
`ifdef MESM6_TIMER_CAPTURE_EN
      cap_d      = cap_rise[g] ? cnt_q : cap_q;
      cap_pend_d = cap_pend_q;
`endif

      if (run) begin
        if (!ctrl_q[C_UPDOWN] || (dir_q == DIR_UP)) begin
          if (cnt_q == prd_q) begin
            if (!ctrl_q[C_UPDOWN]) begin
              cnt_d   = '0;
              prd_evt = 1'b1;
            end else if (prd_q != '0) begin
              dir_d = DIR_DOWN;
              cnt_d = prd_q - CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            dir_d   = DIR_UP;
            cnt_d   = CNT_W'(1);
            prd_evt = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        // One-shot: stop on the period event, leaving CNT at the reloaded value.
        if (prd_evt && !ctrl_q[C_PERIOD]) ctrl_d[C_EN] = 1'b0;
      end

      if (wr_sel) begin
        case (addr_reg)
          REG_CNT:  cnt_d = i_wdata[CNT_W-1:0];
          REG_CMP:  cmp_d = i_wdata[CNT_W-1:0];
          REG_PRD: begin
            prd_d = i_wdata[CNT_W-1:0];
            cnt_d = '0;
            dir_d = DIR_UP;
          end
          REG_CTRL: begin
            ctrl_d = i_wdata[CTRL_W-1:0];
            if (!ctrl_q[C_EN] && i_wdata[C_EN]) begin
              cnt_d = '0;
              pc_d  = '0;
              dir_d = DIR_UP;
            end
          end
          REG_STS: begin
            prd_pend_d = prd_pend_q & ~i_wdata[0];
            cmp_pend_d = cmp_pend_q & ~i_wdata[1];
`ifdef MESM6_TIMER_CAPTURE_EN
            cap_pend_d = cap_pend_q & ~i_wdata[3];
`endif
          end
          REG_PRS: begin
            prs_d = i_wdata[2:0];
            pc_d  = '0;
          end
          default: ;
        endcase
      end

      // Events are applied after the W1C so a same-cycle set wins.
      prd_pend_d = prd_pend_d | prd_evt;
      cmp_pend_d = cmp_pend_d | cmp_evt;
`ifdef MESM6_TIMER_CAPTURE_EN
      cap_pend_d = cap_pend_d | cap_rise[g];
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q      <= '0;
        cmp_q      <= '0;
        prd_q      <= '0;
        ctrl_q     <= '0;
        dir_q      <= DIR_UP;
        prs_q      <= '0;
        pc_q       <= '0;
        prd_pend_q <= 1'b0;
        cmp_pend_q <= 1'b0;
        pwm_q      <= 1'b0;
`ifdef MESM6_TIMER_CAPTURE_EN
        cap_q      <= '0;
        cap_pend_q <= 1'b0;
`endif
      end else begin
        cnt_q      <= cnt_d;
        cmp_q      <= cmp_d;
        prd_q      <= prd_d;
        ctrl_q     <= ctrl_d;
        dir_q      <= dir_d;
        prs_q      <= prs_d;
        pc_q       <= pc_d;
        prd_pend_q <= prd_pend_d;
        cmp_pend_q <= cmp_pend_d;
        pwm_q      <= ctrl_q[C_EN] && (cnt_q < cmp_q);
`ifdef MESM6_TIMER_CAPTURE_EN
        cap_q      <= cap_d;
        cap_pend_q <= cap_pend_d;
`endif
      end
    end

    always_comb begin
      rd_ch = '0;
      case (addr_reg)
        REG_CNT:  rd_ch = 48'(cnt_q);
        REG_CMP:  rd_ch = 48'(cmp_q);
        REG_PRD:  rd_ch = 48'(prd_q);
        REG_CTRL: rd_ch = 48'(ctrl_q);
`ifdef MESM6_TIMER_CAPTURE_EN
        REG_STS:  rd_ch = 48'({cap_pend_q, dir_q == DIR_DOWN, cmp_pend_q, prd_pend_q});
        REG_CAP:  rd_ch = 48'(cap_q);
`else
        REG_STS:  rd_ch = 48'({dir_q == DIR_DOWN, cmp_pend_q, prd_pend_q});
`endif
        REG_PRS:  rd_ch = 48'(prs_q);
        default:  rd_ch = '0;
      endcase
    end

    assign rd_val[g] = rd_ch;
    assign o_pwm[g]  = pwm_q;
`ifdef MESM6_TIMER_CAPTURE_EN
    assign irq_ch[g] = (prd_pend_q && ctrl_q[C_IEN_PRD]) ||
                       (cmp_pend_q && ctrl_q[C_IEN_CMP]) ||
                       (cap_pend_q && ctrl_q[5]);
`else
    assign irq_ch[g] = (prd_pend_q && ctrl_q[C_IEN_PRD]) ||
                       (cmp_pend_q && ctrl_q[C_IEN_CMP]);
`endif
  end

  always_comb begin
    o_rdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (addr_ch == 4'(i)) o_rdata = rd_val[i];
    end
  end

endmodule
